// File: rtl/freq_meas_ctrl.sv
// Gated frequency-measurement sequencer: clear, gate, settle, latch, convert, publish.
// Define FREQ_MEAS_AUTORANGE_EN to switch between long and short (1/10) gates automatically.
module freq_meas_ctrl #(
  parameter int unsigned GATE_CYCLES   = 50_000_000,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CONV_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        hold,
  output logic        gate_en,
  output logic        cnt_clr,
  input  logic [19:0] cnt_val,
  input  logic        cnt_ovf,
  output logic        conv_start,
  output logic [19:0] conv_din,
  input  logic        conv_done,
  output logic [19:0] freq,
  output logic        freq_valid,
  output logic        range,
  output logic [3:0]  led
);

  localparam int unsigned GW = (GATE_CYCLES   > 1) ? $clog2(GATE_CYCLES)   : 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned TW = (CONV_TIMEOUT  > 1) ? $clog2(CONV_TIMEOUT)  : 1;

  localparam logic [GW-1:0] GATE_LONG_LAST  = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0] GATE_SHORT_LAST = GW'(GATE_CYCLES / 10 - 1);
  localparam logic [SW-1:0] SETTLE_LAST     = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST        = TW'(CONV_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, GATE, SETTLE, LATCH, CONV, PUBLISH
  } state_t;

  state_t        state;
  logic [GW-1:0] gate_cnt;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gate_last;
  logic          ovf_flag;
  logic          err;

`ifdef FREQ_MEAS_AUTORANGE_EN
  logic range_q;
  assign range     = range_q;
  assign gate_last = range_q ? GATE_SHORT_LAST : GATE_LONG_LAST;
`else
  assign range     = 1'b0;
  assign gate_last = GATE_LONG_LAST;
`endif

  assign led = {range, err, ovf_flag, gate_en};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      gate_en    <= 1'b0;
      cnt_clr    <= 1'b0;
      conv_start <= 1'b0;
      conv_din   <= '0;
      freq       <= '0;
      freq_valid <= 1'b0;
      ovf_flag   <= 1'b0;
      err        <= 1'b0;
`ifdef FREQ_MEAS_AUTORANGE_EN
      range_q    <= 1'b0;
`endif
    end else begin
      cnt_clr    <= 1'b0;
      conv_start <= 1'b0;
      freq_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state   <= CLEAR;
            cnt_clr <= 1'b1;
          end
        end
        CLEAR: begin
          state    <= GATE;
          gate_en  <= 1'b1;
          gate_cnt <= '0;
        end
        GATE: begin
          if (gate_cnt == gate_last) begin
            gate_en    <= 1'b0;
            settle_cnt <= '0;
            state      <= SETTLE;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= LATCH;
          else settle_cnt <= settle_cnt + 1'b1;
        end
        LATCH: begin
          conv_din   <= cnt_ovf ? '1 : cnt_val;
          ovf_flag   <= cnt_ovf;
`ifdef FREQ_MEAS_AUTORANGE_EN
          // Overflow on the long gate shortens the next one; a small count on the short gate lengthens it.
          if (cnt_ovf && !range_q) range_q <= 1'b1;
          else if (range_q && !cnt_ovf && cnt_val < 20'd10000) range_q <= 1'b0;
`endif
          conv_start <= 1'b1;
          tmo_cnt    <= '0;
          state      <= CONV;
        end
        CONV: begin
          if (conv_done) begin
            state <= PUBLISH;
          end else if (tmo_cnt == TMO_LAST) begin
            err <= 1'b1;
            if (run) begin
              state   <= CLEAR;
              cnt_clr <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        PUBLISH: begin
          if (!hold) begin
            freq       <= conv_din;
            freq_valid <= 1'b1;
          end
          err <= 1'b0;
          if (run) begin
            state   <= CLEAR;
            cnt_clr <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Scoreboard bench for freq_meas_ctrl: per-measurement plans feed a reference model whose
// predictions are queued and consumed by an independent monitor.
module tb_freq_meas_ctrl;

  localparam int G = 100;
  localparam int S = 4;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        hold = 1'b0;
  logic        gate_en, cnt_clr, conv_start, freq_valid, range;
  logic [19:0] cnt_val = '0;
  logic        cnt_ovf = 1'b0;
  logic [19:0] conv_din, freq;
  logic        conv_done = 1'b0;
  logic [3:0]  led;

  always #5 clk = ~clk;

  freq_meas_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CONV_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .hold(hold),
    .gate_en(gate_en), .cnt_clr(cnt_clr), .cnt_val(cnt_val), .cnt_ovf(cnt_ovf),
    .conv_start(conv_start), .conv_din(conv_din), .conv_done(conv_done),
    .freq(freq), .freq_valid(freq_valid), .range(range), .led(led)
  );

  typedef struct {
    logic [19:0] val;
    bit          ovf;
    int          delay;   // conv_done delay after conv_start; negative = never
    bit          hold;
  } plan_t;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int run_cyc = 0;
  bit lat_pending = 0;

  int          gate_q[$];
  logic [19:0] cap_q[$];
  logic [23:0] pub_q[$];   // {freq, led}
  logic [22:0] clr_q[$];   // {freq, err, ovf_flag, range}

  bit          range_m, err_m, ovf_m;
  logic [19:0] freq_m;
  logic [19:0] lat_val = '0;
  bit          lat_ovf = 0;
  int          cur_delay = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic finish_up();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  endtask

  function automatic plan_t mk(logic [19:0] v, bit o, int d, bit h);
    plan_t p;
    p.val = v; p.ovf = o; p.delay = d; p.hold = h;
    return p;
  endfunction

  task automatic model_reset();
    range_m = 0; err_m = 0; ovf_m = 0; freq_m = '0;
    gate_q.delete(); cap_q.delete(); pub_q.delete(); clr_q.delete();
    clr_q.push_back('0);
  endtask

  // Reference model of one whole measurement, evaluated when its clear pulse is seen.
  task automatic issue(input plan_t p);
    logic [19:0] cap;
    lat_val = p.val; lat_ovf = p.ovf; cur_delay = p.delay; hold = p.hold;
    gate_q.push_back(range_m ? G / 10 : G);
    cap = p.ovf ? 20'hFFFFF : p.val;
    cap_q.push_back(cap);
    ovf_m = p.ovf;
`ifdef FREQ_MEAS_AUTORANGE_EN
    if (p.ovf && !range_m) range_m = 1;
    else if (range_m && !p.ovf && p.val < 10000) range_m = 0;
`endif
    if (p.delay < 0) begin
      err_m = 1;
    end else begin
      err_m = 0;
      if (!p.hold) begin
        freq_m = cap;
        pub_q.push_back({freq_m, range_m, 1'b0, ovf_m, 1'b0});
      end
    end
    clr_q.push_back({freq_m, err_m, ovf_m, range_m});
  endtask

  task automatic wait_clr();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cnt_clr) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("clr_wait_timeout", 0, 1);
      finish_up();
    end
  endtask

  task automatic count_gate(input int n);
    int seen = 0;
    for (int i = 0; i < 400 && seen < n; i++) begin
      @(negedge clk);
      if (gate_en) seen++;
    end
    if (seen < n) begin
      chk("gate_wait_timeout", seen, n);
      finish_up();
    end
  endtask

  // Counter model: drives the planned count only in the cycle the controller should latch it.
  initial begin
    int k = 0;
    bit pg = 0;
    bit drive_plan;
    forever begin
      @(negedge clk);
      drive_plan = 0;
      if (!rst_n) begin
        k = 0; pg = 0;
      end else if (k > 0) begin
        k--;
        drive_plan = (k == 0);
      end else if (pg && !gate_en) begin
        k = S;
      end
      pg = rst_n && gate_en;
      if (drive_plan) begin
        cnt_val = lat_val; cnt_ovf = lat_ovf;
      end else begin
        cnt_val = 20'($urandom);
        cnt_ovf = ($urandom_range(0, 1) == 1);
      end
    end
  end

  // Converter model
  initial begin
    int cd = -1;
    forever begin
      @(negedge clk);
      conv_done = 1'b0;
      if (!rst_n) cd = -1;
      else begin
        if (cd == 0) begin conv_done = 1'b1; cd = -1; end
        else if (cd > 0) cd--;
        if (conv_start) begin
          if (cur_delay == 0) conv_done = 1'b1;
          else if (cur_delay > 0) cd = cur_delay - 1;
        end
      end
    end
  end

  // Monitor
  initial begin
    int glen = 0;
    logic [23:0] pe;
    logic [22:0] ce;
    forever begin
      @(negedge clk);
      if (!rst_n) glen = 0;
      else begin
        if (gate_en) glen++;
        else if (glen > 0) begin
          if (gate_q.size() == 0) chk("gate_unexpected", glen, 0);
          else chk("gate_len", glen, gate_q.pop_front());
          glen = 0;
        end
        if (conv_start) begin
          if (cap_q.size() == 0) chk("conv_start_unexpected", 1, 0);
          else chk("conv_din", conv_din, cap_q.pop_front());
        end
        if (freq_valid) begin
          if (pub_q.size() == 0) chk("freq_valid_unexpected", freq, 0);
          else begin
            pe = pub_q.pop_front();
            chk("pub_freq", freq, pe[23:4]);
            chk("pub_led", led, pe[3:0]);
          end
          if (lat_pending) begin
            chk("first_latency", cyc - run_cyc - 1, G + S + 4);
            lat_pending = 0;
          end
        end
        if (cnt_clr) begin
          if (clr_q.size() == 0) chk("cnt_clr_unexpected", 1, 0);
          else begin
            ce = clr_q.pop_front();
            chk("clr_freq", freq, ce[22:3]);
            chk("clr_led", led, {ce[0], ce[2], ce[1], 1'b0});
          end
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycles 60000 reached, limit 60000");
    $fatal(1);
  end

  initial begin
    plan_t fixed[9];
    plan_t p;
    fixed[0] = mk(20'd12345, 0, 0, 0);
    fixed[1] = mk(20'd12345, 0, 3, 0);
    fixed[2] = mk(20'd54321, 1, 1, 0);
    fixed[3] = mk(20'd100,   1, 2, 0);
    fixed[4] = mk(20'd9000,  0, 0, 0);
    fixed[5] = mk(20'd12345, 0, -1, 0);
    fixed[6] = mk(20'd12345, 0, 3, 0);
    fixed[7] = mk(20'd777,   0, 2, 1);
    fixed[8] = mk(20'd4242,  0, 1, 0);

    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {gate_en, cnt_clr, conv_start, conv_din, freq, freq_valid, led}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_quiet", {gate_en, cnt_clr, conv_start, freq_valid}, '0);
    run = 1'b1;
    run_cyc = cyc;
    lat_pending = 1;

    foreach (fixed[i]) begin
      wait_clr();
      issue(fixed[i]);
    end

    for (int i = 0; i < 20; i++) begin
      p.val   = ($urandom_range(0, 2) == 0) ? 20'($urandom_range(0, 19999)) : 20'($urandom);
      p.ovf   = ($urandom_range(0, 4) == 0);
      p.delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      p.hold  = ($urandom_range(0, 5) == 0);
      wait_clr();
      issue(p);
    end

    // Reset in the middle of a gate window
    wait_clr();
    issue(mk(20'd31337, 0, 1, 0));
    count_gate(30);
    #2 rst_n = 1'b0;
    #1;
    chk("midgate_reset_outputs", {gate_en, cnt_clr, conv_start, conv_din, freq_valid, led}, '0);
    chk("midgate_reset_freq", freq, 20'd0);
    chk("midgate_reset_range", range, 1'b0);
    model_reset();
    hold = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_clr();
    issue(mk(20'd12345, 0, 3, 0));
    wait_clr();
    issue(mk(20'd2024, 0, 0, 0));

    // Drop run mid-gate: the measurement finishes and the controller idles.
    wait_clr();
    issue(mk(20'd6060, 0, 2, 0));
    count_gate(50);
    run = 1'b0;
    void'(clr_q.pop_back());
    for (int i = 0; i < 400 && pub_q.size() != 0; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    chk("stopped_gate_en", gate_en, 1'b0);
    chk("stopped_freq", freq, 20'd6060);
    chk("pending_pub", pub_q.size(), 0);
    chk("pending_gate", gate_q.size(), 0);
    chk("pending_conv", cap_q.size(), 0);
    chk("pending_clr", clr_q.size(), 0);
    finish_up();
  end

endmodule

// File: doc/freq_meas_ctrl.md
FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

Interface
REQ-001 SHALL have parameters: GATE_CYCLES, 50_000_000, clk cycles per long gate window (1 s); SETTLE_CYCLES, 4, post-gate wait for counter-side synchroniser flush; CONV_TIMEOUT, 64, max cycles to wait for conv_done.
REQ-002 SHALL have ports:
 clk  input  1  system clock, all logic rising-edge;
 rst_n  input  1  asynchronous active-low reset;
 run  input  1  1 = continuous measurement, 0 = stop after current cycle;
 hold  input  1  1 = freeze published result, measurement continues;
 gate_en  output  1  counter enable window to edge counter;
 cnt_clr  output  1  one-cycle counter clear pulse;
 cnt_val  input  20  edge count from counter;
 cnt_ovf  input  1  counter saturated during gate;
 conv_start  output  1  one-cycle start pulse to binary-to-BCD converter;
 conv_din  output  20  value to convert;
 conv_done  input  1  converter completion pulse;
 freq  output  20  published frequency;
 freq_valid  output  1  one-cycle pulse on each publish;
 range  output  1  0 = long gate, 1 = short gate (decimal-point hint);
 led  output  4  status {range, err, ovf_flag, gate_en}.

Function
REQ-003 SHALL implement states IDLE, CLEAR, GATE, SETTLE, LATCH, CONV, PUBLISH.
REQ-004 IDLE: outputs quiescent; run=1 -> CLEAR next cycle.
REQ-005 CLEAR: cnt_clr=1 for exactly 1 cycle -> GATE.
REQ-006 GATE: gate_en=1 for exactly gate-length cycles (GATE_CYCLES, or GATE_CYCLES/10 when range=1) -> SETTLE; gate_en SHALL not glitch (registered output).
REQ-007 SETTLE: gate_en=0 for SETTLE_CYCLES cycles -> LATCH.
REQ-008 LATCH: capture cnt_val and cnt_ovf into internal registers in 1 cycle -> CONV; cnt_ovf=1 SHALL saturate captured value to 20'hFFFFF and set ovf_flag, else clear ovf_flag.
REQ-009 CONV: conv_start=1 on first CONV cycle only, conv_din = captured value held stable throughout CONV; conv_done -> PUBLISH; no conv_done within CONV_TIMEOUT cycles -> set err, go CLEAR (run=1) or IDLE (run=0), no publish.
REQ-010 conv_done arriving in the same cycle as conv_start SHALL be accepted.
REQ-011 PUBLISH (1 cycle): if hold=0, freq <= captured value and freq_valid=1; if hold=1, freq unchanged and freq_valid=0; err cleared on successful publish; then CLEAR if run=1 else IDLE.
REQ-012 run deassert in any non-IDLE state SHALL NOT abort; the cycle completes through PUBLISH, then IDLE.
REQ-013 Latency run rise to first freq_valid (range=0, immediate conv_done): 1 + GATE_CYCLES + SETTLE_CYCLES + 1 + 1 + 1 cycles.
REQ-014 Gate and timeout counters SHALL be sized by $clog2 of their parameter; no wrap-around inside a window.
REQ-015 cnt_val/cnt_ovf SHALL be sampled only in LATCH; changes elsewhere ignored.

Reset
REQ-016 rst_n=0 SHALL asynchronously force IDLE, gate_en=0, cnt_clr=0, conv_start=0, conv_din=0, freq=0, freq_valid=0, range=0, ovf_flag=0, err=0, all counters 0.
REQ-017 Reset mid-GATE or mid-CONV SHALL discard the measurement; first cycle after release is IDLE.

Configuration
REQ-018 Macro FREQ_MEAS_AUTORANGE_EN.
REQ-019 Defined: LATCH with ovf and range=0 -> range=1 for next gate; LATCH with range=1 and captured value < 10000 (no ovf) -> range=0 for next gate; range changes only in LATCH; ovf in range=1 stays saturated.
REQ-020 Undefined: range tied 0, gate always GATE_CYCLES, ovf only saturates.

Verification (GATE_CYCLES=100, SETTLE_CYCLES=4, CONV_TIMEOUT=8)
REQ-021 run=1, cnt_val=12345, conv_done 3 cycles after conv_start -> gate_en high exactly 100 cycles, freq=12345, freq_valid one pulse, cycle repeats.
REQ-022 cnt_ovf=1 at LATCH -> freq=20'hFFFFF, led[1]=1; with FREQ_MEAS_AUTORANGE_EN next gate 10 cycles, range=1; with 9000 then -> range back 0.
REQ-023 conv_done never asserted -> 8 cycles in CONV, led[2]=1, no freq_valid, new cnt_clr pulse; next good cycle clears led[2].
REQ-024 hold=1 during PUBLISH with cnt_val=777 -> freq keeps previous 12345, no freq_valid; hold=0 next cycle publishes new value.
REQ-025 run falls at gate cycle 50 -> measurement completes, one freq_valid, then IDLE with gate_en=0.
REQ-026 rst_n low at gate cycle 30 -> all outputs to reset values same cycle; after release with run=1, CLEAR then full 100-cycle gate.
